// File: rtl/sram_arb_pkg.sv
// Shared types and default sizing for the SRAM bank read arbiter.
// Also holds the round-robin pointer advance helper.
package sram_arb_pkg;

    localparam int unsigned REQ_CNT_DFLT        = 4;
    localparam int unsigned BANK_CNT_DFLT       = 4;
    localparam int unsigned BANK_CNT_LG2_DFLT   = 2;
    localparam int unsigned BANK_DEPTH_LG2_DFLT = 10;
    localparam int unsigned DATA_WIDTH_DFLT     = 512;
    localparam int unsigned RD_LAT              = 1;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

    // Pointer moves to the slot just after the winner, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, wrapping.
// Produces a one-hot grant plus the winner index.
module rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] gnt_idx_o,
    output logic            valid_o
);

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        valid_o   = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            logic [IdxW-1:0] idx;
            idx = IdxW'((32'(ptr_i) + i) % N);
            if (!valid_o && req_i[idx]) begin
                valid_o     = 1'b1;
                gnt_o[idx]  = 1'b1;
                gnt_idx_o   = idx;
            end
        end
    end

endmodule

// File: rtl/sram_bank_rd_arbiter.sv
// Shares single-read-port SRAM banks between read requesters. Each bank holds a
// round-robin arbiter with burst lock; read data returns to the owner after RD_LAT.
module sram_bank_rd_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned REQ_CNT             = REQ_CNT_DFLT,
    parameter int unsigned SRAM_BANK_CNT       = BANK_CNT_DFLT,
    parameter int unsigned SRAM_BANK_CNT_LG2   = BANK_CNT_LG2_DFLT,
    parameter int unsigned SRAM_BANK_DEPTH_LG2 = BANK_DEPTH_LG2_DFLT,
    parameter int unsigned SRAM_DATA_WIDTH     = DATA_WIDTH_DFLT
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [REQ_CNT-1:0]                           rreq_i,
    input  logic [REQ_CNT*SRAM_BANK_CNT_LG2-1:0]         rid_i,
    input  logic [REQ_CNT*SRAM_BANK_DEPTH_LG2-1:0]       raddr_i,
    input  logic [REQ_CNT-1:0]                           reb_i,
    input  logic [REQ_CNT-1:0]                           rlast_i,
    output logic [REQ_CNT-1:0]                           rack_o,
    output logic [REQ_CNT*SRAM_DATA_WIDTH-1:0]           rdata_o,
    output logic [REQ_CNT-1:0]                           rvalid_o,
    output logic [SRAM_BANK_CNT-1:0]                     bank_re_o,
    output logic [SRAM_BANK_CNT*SRAM_BANK_DEPTH_LG2-1:0] bank_addr_o,
    input  logic [SRAM_BANK_CNT*SRAM_DATA_WIDTH-1:0]     bank_rdata_i
);

    localparam int unsigned IdxW = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;
    localparam int unsigned BW   = SRAM_BANK_CNT_LG2;
    localparam int unsigned AW   = SRAM_BANK_DEPTH_LG2;
    localparam int unsigned DW   = SRAM_DATA_WIDTH;

    logic [SRAM_BANK_CNT-1:0]         busy_vec;
    logic [SRAM_BANK_CNT-1:0]         rvld_vec;
    logic [SRAM_BANK_CNT*IdxW-1:0]    owner_flat;
    logic [SRAM_BANK_CNT*IdxW-1:0]    rown_flat;
    logic [SRAM_BANK_CNT*REQ_CNT-1:0] rack_flat;
    logic [REQ_CNT-1:0]               owns;

    // A requester holding any bank may not compete for another one.
    always_comb begin
        owns = '0;
        for (int b = 0; b < SRAM_BANK_CNT; b++) begin
            if (busy_vec[b]) begin
                owns[owner_flat[b*IdxW +: IdxW]] = 1'b1;
            end
        end
    end

    for (genvar b = 0; b < SRAM_BANK_CNT; b++) begin : g_bank
        arb_state_e      state_q, state_d;
        logic [IdxW-1:0] owner_q, owner_d;
        logic [IdxW-1:0] ptr_q, ptr_d;
        logic [REQ_CNT-1:0] rack_q, rack_d;
        logic [REQ_CNT-1:0] elig;
        logic [REQ_CNT-1:0] gnt;
        logic [IdxW-1:0] gnt_idx;
        logic            gnt_vld;
        logic            busy;
        logic            beat_re;
        logic            beat_last;
        logic            rvld_q;
        logic [IdxW-1:0] rown_q;

        assign busy      = (state_q == ARB_BUSY);
        assign beat_re   = busy && reb_i[owner_q];
        assign beat_last = beat_re && rlast_i[owner_q];

        always_comb begin
            elig = '0;
            for (int p = 0; p < REQ_CNT; p++) begin
                elig[p] = rreq_i[p] && (rid_i[p*BW +: BW] == BW'(b)) && !owns[p] && !rack_o[p];
            end
        end

        rr_arbiter #(
            .N    (REQ_CNT),
            .IdxW (IdxW)
        ) u_rr (
            .req_i     (elig),
            .ptr_i     (ptr_q),
            .gnt_o     (gnt),
            .gnt_idx_o (gnt_idx),
            .valid_o   (gnt_vld)
        );

        always_comb begin
            state_d = state_q;
            owner_d = owner_q;
            ptr_d   = ptr_q;
            rack_d  = '0;
            unique case (state_q)
                ARB_IDLE: begin
                    if (gnt_vld) begin
                        state_d = ARB_BUSY;
                        owner_d = gnt_idx;
                        rack_d  = gnt;
                        ptr_d   = IdxW'(rr_next(32'(gnt_idx), REQ_CNT));
                    end
                end
                ARB_BUSY: begin
                    // The bank re-arbitrates in the cycle after the last beat.
                    if (beat_last) begin
                        state_d = ARB_IDLE;
                    end
                end
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= ARB_IDLE;
                owner_q <= '0;
                ptr_q   <= '0;
                rack_q  <= '0;
                rvld_q  <= 1'b0;
                rown_q  <= '0;
            end else begin
                state_q <= state_d;
                owner_q <= owner_d;
                ptr_q   <= ptr_d;
                rack_q  <= rack_d;
                rvld_q  <= beat_re;
                rown_q  <= owner_q;
            end
        end

        assign bank_re_o[b]                = beat_re;
        assign bank_addr_o[b*AW +: AW]     = busy ? raddr_i[32'(owner_q)*AW +: AW] : '0;
        assign busy_vec[b]                 = busy;
        assign rvld_vec[b]                 = rvld_q;
        assign owner_flat[b*IdxW +: IdxW]  = owner_q;
        assign rown_flat[b*IdxW +: IdxW]   = rown_q;
        assign rack_flat[b*REQ_CNT +: REQ_CNT] = rack_q;
    end

    always_comb begin
        rack_o = '0;
        for (int b = 0; b < SRAM_BANK_CNT; b++) begin
            rack_o = rack_o | rack_flat[b*REQ_CNT +: REQ_CNT];
        end
    end

    // Return data is steered by the owner captured alongside the beat.
    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        for (int b = 0; b < SRAM_BANK_CNT; b++) begin
            if (rvld_vec[b]) begin
                rvalid_o[rown_flat[b*IdxW +: IdxW]] = 1'b1;
                rdata_o[32'(rown_flat[b*IdxW +: IdxW])*DW +: DW] =
                    rdata_o[32'(rown_flat[b*IdxW +: IdxW])*DW +: DW] | bank_rdata_i[b*DW +: DW];
            end
        end
    end

endmodule

// File: tb/tb_sram_bank_rd_arbiter.sv
// Randomized bench for sram_bank_rd_arbiter: requesters follow a spec-level model of
// grants, and a scoreboard checks returned read data against a bank memory model.
module tb_sram_bank_rd_arbiter;
    import sram_arb_pkg::*;

    localparam int N  = 4;
    localparam int NB = 4;
    localparam int BW = 2;
    localparam int AW = 10;
    localparam int DW = 512;
    localparam int NCYC = 2400;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      rreq_i;
    logic [N*BW-1:0]   rid_i;
    logic [N*AW-1:0]   raddr_i;
    logic [N-1:0]      reb_i;
    logic [N-1:0]      rlast_i;
    logic [N-1:0]      rack_o;
    logic [N*DW-1:0]   rdata_o;
    logic [N-1:0]      rvalid_o;
    logic [NB-1:0]     bank_re_o;
    logic [NB*AW-1:0]  bank_addr_o;
    logic [NB*DW-1:0]  bank_rdata_i;

    always #5 clk = ~clk;

    sram_bank_rd_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .rreq_i       (rreq_i),
        .rid_i        (rid_i),
        .raddr_i      (raddr_i),
        .reb_i        (reb_i),
        .rlast_i      (rlast_i),
        .rack_o       (rack_o),
        .rdata_o      (rdata_o),
        .rvalid_o     (rvalid_o),
        .bank_re_o    (bank_re_o),
        .bank_addr_o  (bank_addr_o),
        .bank_rdata_i (bank_rdata_i)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit run    = 1'b0;

    typedef struct {
        int             due;
        logic [DW-1:0]  data;
    } exp_t;

    exp_t exp_q [N][$];

    // Reference model state: bank owner (-1 = idle), RR pointer, grant pulse this cycle.
    int m_owner [NB];
    int m_ptr   [NB];
    bit m_rack  [N];

    // Requester behaviour: 0 idle, 1 requesting, 2 owning a bank.
    int rq_state [N];
    int rq_bank  [N];
    int rq_beats [N];
    int rq_addr  [N];

    function automatic logic [DW-1:0] mem_word(input int b, input int a);
        logic [DW-1:0] w;
        for (int k = 0; k < DW / 32; k++) begin
            w[k*32 +: 32] = (32'(b + 1) * 32'h9E3779B1) ^ (32'(a) * 32'h85EBCA6B)
                          ^ (32'(k) * 32'hC2B2AE35) ^ 32'h1234_5678;
        end
        return w;
    endfunction

    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            bank_rdata_i[b*DW +: DW] <= bank_re_o[b] ? mem_word(b, int'(bank_addr_o[b*AW +: AW]))
                                                     : {DW{1'b1}};
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        rreq_i  = '0;
        rid_i   = '0;
        raddr_i = '0;
        reb_i   = '0;
        rlast_i = '0;
    endtask

    task automatic model_reset();
        for (int b = 0; b < NB; b++) begin
            m_owner[b] = -1;
            m_ptr[b]   = 0;
        end
        for (int p = 0; p < N; p++) begin
            m_rack[p]   = 1'b0;
            rq_state[p] = 0;
            exp_q[p].delete();
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, " rack"},   DW'(rack_o),      '0);
        chk({tag, " rvalid"}, DW'(rvalid_o),    '0);
        chk({tag, " re"},     DW'(bank_re_o),   '0);
        chk({tag, " addr"},   DW'(bank_addr_o), '0);
        for (int p = 0; p < N; p++) begin
            chk($sformatf("%s rdata p%0d", tag, p), rdata_o[p*DW +: DW], '0);
        end
    endtask

    // Grant rules: an idle bank picks the first eligible requester scanning from its
    // pointer; a busy bank frees after its owner's last beat.
    task automatic model_step();
        int nxt_owner [NB];
        bit nxt_rack  [N];
        bit owns      [N];
        for (int p = 0; p < N; p++) begin
            nxt_rack[p] = 1'b0;
            owns[p]     = 1'b0;
        end
        for (int b = 0; b < NB; b++) begin
            if (m_owner[b] >= 0) owns[m_owner[b]] = 1'b1;
        end
        for (int b = 0; b < NB; b++) begin
            nxt_owner[b] = m_owner[b];
            if (m_owner[b] >= 0) begin
                if (reb_i[m_owner[b]] && rlast_i[m_owner[b]]) nxt_owner[b] = -1;
            end else begin
                for (int i = 0; i < N; i++) begin
                    int q;
                    q = (m_ptr[b] + i) % N;
                    if (rreq_i[q] && int'(rid_i[q*BW +: BW]) == b && !owns[q] && !m_rack[q]) begin
                        nxt_owner[b] = q;
                        nxt_rack[q]  = 1'b1;
                        m_ptr[b]     = (q + 1) % N;
                        break;
                    end
                end
            end
        end
        for (int b = 0; b < NB; b++) m_owner[b] = nxt_owner[b];
        for (int p = 0; p < N; p++) m_rack[p] = nxt_rack[p];
    endtask

    task automatic step_cycle(input bit allow_new, input bit hot);
        logic [N-1:0]     exp_rack;
        logic [NB-1:0]    exp_re;
        logic [NB*AW-1:0] exp_addr;
        for (int p = 0; p < N; p++) exp_rack[p] = m_rack[p];
        chk($sformatf("rack c%0d", cyc), DW'(rack_o), DW'(exp_rack));
        for (int p = 0; p < N; p++) begin
            if (m_rack[p]) rq_state[p] = 2;
        end
        for (int p = 0; p < N; p++) begin
            rreq_i[p]            = 1'b0;
            reb_i[p]             = 1'b0;
            rlast_i[p]           = 1'b0;
            raddr_i[p*AW +: AW]  = AW'($urandom);
            rid_i[p*BW +: BW]    = BW'($urandom);
            if (rq_state[p] == 0 && allow_new && $urandom_range(0, 2) == 0) begin
                rq_state[p] = 1;
                rq_bank[p]  = hot ? int'($urandom_range(0, 1)) : int'($urandom_range(0, NB - 1));
                rq_beats[p] = int'($urandom_range(1, 4));
                rq_addr[p]  = int'($urandom_range(0, 1023));
            end
            case (rq_state[p])
                1: begin
                    rreq_i[p]         = 1'b1;
                    rid_i[p*BW +: BW] = BW'(rq_bank[p]);
                end
                2: begin
                    if ($urandom_range(0, 3) != 0) begin
                        reb_i[p]            = 1'b1;
                        raddr_i[p*AW +: AW] = AW'(rq_addr[p]);
                        rlast_i[p]          = (rq_beats[p] == 1);
                        rq_addr[p]          = (rq_addr[p] + 1) % 1024;
                        rq_beats[p]--;
                        if (rq_beats[p] == 0) rq_state[p] = 0;
                    end
                end
                default: begin
                    // Stray beats from non-owners must be ignored by every bank.
                    if ($urandom_range(0, 4) == 0) reb_i[p] = 1'b1;
                end
            endcase
        end
        #1;
        exp_re   = '0;
        exp_addr = '0;
        for (int b = 0; b < NB; b++) begin
            if (m_owner[b] >= 0) begin
                int p;
                exp_t e;
                p = m_owner[b];
                exp_re[b]              = reb_i[p];
                exp_addr[b*AW +: AW]   = raddr_i[p*AW +: AW];
                if (reb_i[p]) begin
                    e.due  = cyc + int'(RD_LAT);
                    e.data = mem_word(b, int'(raddr_i[p*AW +: AW]));
                    exp_q[p].push_back(e);
                end
            end
        end
        chk($sformatf("bank_re c%0d", cyc),   DW'(bank_re_o),   DW'(exp_re));
        chk($sformatf("bank_addr c%0d", cyc), DW'(bank_addr_o), DW'(exp_addr));
        model_step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        #1;
        chk_zero_outputs($sformatf("midrst c%0d", cyc));
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
    endtask

    // Scoreboard monitor: every returned beat must match the oldest expected beat.
    always @(negedge clk) begin
        if (run && !rst) begin
            for (int p = 0; p < N; p++) begin
                bit   ev;
                exp_t e;
                ev = (exp_q[p].size() > 0) && (exp_q[p][0].due == cyc);
                chk($sformatf("rvalid p%0d c%0d", p, cyc), DW'(rvalid_o[p]), DW'(ev));
                if (ev) begin
                    e = exp_q[p].pop_front();
                    chk($sformatf("rdata p%0d c%0d", p, cyc), rdata_o[p*DW +: DW], e.data);
                end else begin
                    chk($sformatf("rdata_idle p%0d c%0d", p, cyc), rdata_o[p*DW +: DW], '0);
                end
            end
        end
    end

    assert property (@(posedge clk) disable iff (rst) (rlast_i & ~reb_i) == '0);

    for (genvar p = 0; p < N; p++) begin : g_sva
        assert property (@(posedge clk) disable iff (rst)
            rreq_i[p] && !rack_o[p] |=> rack_o[p] || (rreq_i[p] && $stable(rid_i[p*BW +: BW])));
        assert property (@(posedge clk) disable iff (rst) rack_o[p] |-> !rreq_i[p]);
    end

    initial begin
        rst = 1'b1;
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        rst = 1'b0;
        run = 1'b1;
        for (int k = 0; k < NCYC; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (k == 700 || k == 1650) begin
                do_reset();
            end else begin
                step_cycle(1'b1, k >= 1200);
            end
        end
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            step_cycle(1'b0, 1'b0);
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < N; p++) begin
            chk($sformatf("drain p%0d", p), DW'(exp_q[p].size()), '0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
